// File: rtl/spi_slave_if.sv
// SPI mode-0 slave (MSB first) with a one-word TX buffer, back-to-back word support,
// and a sticky error flag for TX underrun and aborted words.
module spi_slave_if #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  I_CLK,
    input  logic                  I_RESETN,
    input  logic                  SCLK_SLAVE,
    input  logic                  SS_N_SLAVE,
    input  logic                  MOSI_SLAVE,
    output logic                  MISO_SLAVE,
    input  logic                  I_TX_EN,
    input  logic [DATA_WIDTH-1:0] I_WDATA,
    output logic                  O_TX_READY,
    output logic [DATA_WIDTH-1:0] O_RDATA,
    output logic                  O_RX_VALID,
    output logic                  O_ERR,
    input  logic                  I_ERR_CLR,
    output logic                  O_BUSY
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                  state;
    logic                    sclk_s1, sclk_s2, sclk_prev;
    logic                    ss_s1, ss_s2, ss_prev;
    logic                    mosi_s1, mosi_s2;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   tx_sr;
    logic [DATA_WIDTH-1:0]   rx_sr;
    logic [DATA_WIDTH-1:0]   rx_next;
    logic [DATA_WIDTH-1:0]   tx_buf;
    logic                    tx_full;
    logic                    sclk_rise, sclk_fall, ss_fall;
    logic                    do_load;

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            ss_s1     <= 1'b1;
            ss_s2     <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= SCLK_SLAVE;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            ss_s1     <= SS_N_SLAVE;
            ss_s2     <= ss_s1;
            ss_prev   <= ss_s2;
            mosi_s1   <= MOSI_SLAVE;
            mosi_s2   <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign sclk_fall = ~sclk_s2 & sclk_prev;
    assign ss_fall   = ~ss_s2 & ss_prev;

    // A falling SCLK right after the counter wrapped starts the next word instead of shifting.
    always_comb begin
        rx_next = (rx_sr << 1) | DATA_WIDTH'(mosi_s2);
        do_load = 1'b0;
        if (state == IDLE) begin
            do_load = ss_fall;
        end else if (!ss_s2 && sclk_fall && bit_cnt == '0) begin
            do_load = 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            O_RDATA    <= '0;
            O_RX_VALID <= 1'b0;
            O_ERR      <= 1'b0;
        end else begin
            O_RX_VALID <= 1'b0;
            if (I_ERR_CLR) begin
                O_ERR <= 1'b0;
            end
            if (I_TX_EN && !tx_full) begin
                tx_buf  <= I_WDATA;
                tx_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= ACTIVE;
                        bit_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (ss_s2) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            O_ERR <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            O_RDATA    <= rx_next;
                            O_RX_VALID <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall && bit_cnt != '0) begin
                        tx_sr <= tx_sr << 1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Error set is placed after the clear so a coincident underrun wins.
            if (do_load) begin
                if (tx_full) begin
                    tx_sr   <= tx_buf;
                    tx_full <= 1'b0;
                end else begin
                    tx_sr <= '0;
                    O_ERR <= 1'b1;
                end
            end
        end
    end

    assign O_BUSY     = (state == ACTIVE);
    assign O_TX_READY = ~tx_full;
    assign MISO_SLAVE = O_BUSY & tx_sr[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: SPI master tasks drive pins; a transaction-level model
// (3-cycle pin-to-output latency) is compared against every DUT output each cycle.
module tb_spi_slave_if;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, sclk, ss_n, mosi, miso;
    logic         tx_en, tx_ready, rx_valid, err, err_clr, busy;
    logic [W-1:0] wdata, rdata;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(W)) dut (
        .I_CLK      (clk),
        .I_RESETN   (rst_n),
        .SCLK_SLAVE (sclk),
        .SS_N_SLAVE (ss_n),
        .MOSI_SLAVE (mosi),
        .MISO_SLAVE (miso),
        .I_TX_EN    (tx_en),
        .I_WDATA    (wdata),
        .O_TX_READY (tx_ready),
        .O_RDATA    (rdata),
        .O_RX_VALID (rx_valid),
        .O_ERR      (err),
        .I_ERR_CLR  (err_clr),
        .O_BUSY     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    bit check_on = 1'b0;

    // Reference model state: what each output must be right now.
    bit           m_busy, m_ready, m_err, m_valid;
    logic [W-1:0] m_buf, m_tx, m_rdata, m_rx;
    int           m_cnt, m_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            check("busy",     busy,     m_busy);
            check("tx_ready", tx_ready, m_ready);
            check("err",      err,      m_err);
            check("rx_valid", rx_valid, m_valid);
            check("rdata",    rdata,    m_rdata);
            check("miso",     miso,     m_busy ? m_tx[W-1-m_bit] : 1'b0);
        end
    end

    always @(negedge clk) if (rx_valid === 1'b1) n_valid++;

    task automatic model_reset();
        m_busy = 0; m_ready = 1; m_err = 0; m_valid = 0;
        m_buf = '0; m_tx = '0; m_rdata = '0; m_rx = '0;
        m_cnt = 0; m_bit = 0;
    endtask

    task automatic model_reload();
        if (!m_ready) begin
            m_tx = m_buf;
            m_ready = 1;
        end else begin
            m_tx = '0;
            m_err = 1;
        end
        m_bit = 0;
    endtask

    task automatic model_sclk(input bit v);
        if (!m_busy) return;
        if (v) begin
            m_rx = {m_rx[W-2:0], mosi};
            m_cnt++;
            if (m_cnt == W) begin
                m_cnt = 0;
                m_rdata = m_rx;
                m_valid = 1;
            end
        end else if (m_cnt == 0) begin
            model_reload();
        end else begin
            m_bit++;
        end
    endtask

    task automatic model_ss(input bit v);
        if (!v && !m_busy) begin
            m_busy = 1;
            m_cnt = 0;
            model_reload();
        end else if (v && m_busy) begin
            m_busy = 0;
            if (m_cnt != 0) m_err = 1;
            m_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_load(input logic [W-1:0] d);
        tx_en = 1; wdata = d;
        tick();
        tx_en = 0;
        if (m_ready) begin
            m_buf = d;
            m_ready = 0;
        end
    endtask

    task automatic err_clear();
        err_clr = 1;
        tick();
        err_clr = 0;
        m_err = 0;
    endtask

    // One SCLK phase of 6 system clocks; an optional TX load lands in the spare cycles.
    task automatic pin_sclk(input bit v, input bit ld, input logic [W-1:0] d);
        sclk = v;
        tick(); tick(); tick();
        model_sclk(v);
        tick();
        m_valid = 0;
        if (ld) begin
            tx_en = 1; wdata = d;
        end
        tick();
        tx_en = 0;
        if (ld && m_ready) begin
            m_buf = d;
            m_ready = 0;
        end
        tick();
    endtask

    // SS_N change; error clear / TX load can be made to coincide with the SS_N effect.
    task automatic pin_ss(input bit v, input bit clr, input bit ld, input logic [W-1:0] d);
        bit r;
        ss_n = v;
        tick(); tick();
        if (clr) err_clr = 1;
        if (ld) begin
            tx_en = 1; wdata = d;
        end
        tick();
        err_clr = 0;
        tx_en = 0;
        r = m_ready;
        if (clr) m_err = 0;
        model_ss(v);
        if (ld && r) begin
            m_buf = d;
            m_ready = 0;
        end
        tick(); tick(); tick();
    endtask

    task automatic spi_word(input logic [W-1:0] mo, input bit last, input int ld_at,
                            input logic [W-1:0] ld_d, input int abort_at,
                            output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < W; i++) begin
            if (i == abort_at) break;
            mosi = mo[W-1-i];
            got[W-1-i] = miso;
            pin_sclk(1'b1, ld_at == i, ld_d);
            if (!(last && i == W-1)) pin_sclk(1'b0, 1'b0, '0);
        end
    endtask

    task automatic finish_xfer();
        pin_ss(1'b1, 1'b0, 1'b0, '0);
        pin_sclk(1'b0, 1'b0, '0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] got, got2;
        int v0, nw, ab, ld_at;
        bit lastw;

        rst_n = 0; sclk = 0; ss_n = 1; mosi = 0;
        tx_en = 0; wdata = '0; err_clr = 0;
        model_reset();
        check_on = 1;
        repeat (3) tick();
        rst_n = 1;
        repeat (3) tick();

        check("rst_ready", tx_ready, 1);
        check("rst_busy",  busy, 0);
        check("rst_err",   err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_miso",  miso, 0);

        // Single word with preloaded TX data
        tx_load(8'hA5);
        check("t1_ld_ready", tx_ready, 0);
        v0 = n_valid;
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'h3C, 1'b1, -1, '0, W, got);
        finish_xfer();
        check("t1_miso",   got, 8'hA5);
        check("t1_rdata",  rdata, 8'h3C);
        check("t1_pulses", n_valid - v0, 1);
        check("t1_err",    err, 0);
        check("t1_ready",  tx_ready, 1);

        // Two back-to-back words, second TX word loaded mid-word
        tx_load(8'h11);
        v0 = n_valid;
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'hF0, 1'b0, 2, 8'h22, W, got);
        check("t2_rdata0", rdata, 8'hF0);
        spi_word(8'h0F, 1'b1, -1, '0, W, got2);
        finish_xfer();
        check("t2_miso0",  got, 8'h11);
        check("t2_miso1",  got2, 8'h22);
        check("t2_rdata1", rdata, 8'h0F);
        check("t2_pulses", n_valid - v0, 2);
        check("t2_err",    err, 0);

        // Underrun
        v0 = n_valid;
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'h55, 1'b1, -1, '0, W, got);
        finish_xfer();
        check("t3_miso",   got, 8'h00);
        check("t3_rdata",  rdata, 8'h55);
        check("t3_err",    err, 1);
        check("t3_pulses", n_valid - v0, 1);
        err_clear();
        check("t3_errclr", err, 0);

        // Abort after 5 bits
        tx_load(8'hC3);
        v0 = n_valid;
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'hAA, 1'b0, -1, '0, 5, got);
        pin_ss(1'b1, 1'b0, 1'b0, '0);
        check("t4_pulses", n_valid - v0, 0);
        check("t4_rdata",  rdata, 8'h55);
        check("t4_err",    err, 1);
        check("t4_busy",   busy, 0);
        err_clear();

        // Load while buffer full is ignored
        tx_load(8'h66);
        tx_load(8'h77);
        check("t5_ready", tx_ready, 0);
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'h5A, 1'b1, -1, '0, W, got);
        finish_xfer();
        check("t5_miso", got, 8'h66);
        check("t5_err",  err, 0);

        // TX load coinciding with a load from an empty buffer
        pin_ss(1'b0, 1'b0, 1'b1, 8'h99);
        check("t6_ready", tx_ready, 0);
        check("t6_err",   err, 1);
        spi_word(8'h12, 1'b1, -1, '0, W, got);
        finish_xfer();
        check("t6_miso0", got, 8'h00);
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'h34, 1'b1, -1, '0, W, got);
        finish_xfer();
        check("t6_miso1", got, 8'h99);

        // Error clear coinciding with an abort: set wins
        err_clear();
        tx_load(8'h44);
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'hFF, 1'b0, -1, '0, 3, got);
        pin_ss(1'b1, 1'b1, 1'b0, '0);
        check("t7_setwins", err, 1);

        // Reset at bit 4, then a clean transfer
        err_clear();
        tx_load(8'hE7);
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'hC6, 1'b0, -1, '0, 4, got);
        rst_n = 0;
        model_reset();
        #2;
        check("t8_rst_miso",  miso, 0);
        check("t8_rst_ready", tx_ready, 1);
        check("t8_rst_rdata", rdata, 0);
        check("t8_rst_valid", rx_valid, 0);
        check("t8_rst_err",   err, 0);
        check("t8_rst_busy",  busy, 0);
        ss_n = 1; sclk = 0;
        tick(); tick();
        rst_n = 1;
        repeat (6) tick();
        tx_load(8'h5A);
        v0 = n_valid;
        pin_ss(1'b0, 1'b0, 1'b0, '0);
        spi_word(8'h81, 1'b1, -1, '0, W, got);
        finish_xfer();
        check("t8_rdata",  rdata, 8'h81);
        check("t8_miso",   got, 8'h5A);
        check("t8_pulses", n_valid - v0, 1);

        // Randomized transfers checked by the per-cycle model comparison
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(3) == 0) err_clear();
            if ($urandom_range(1) == 1) tx_load(W'($urandom));
            nw = int'($urandom_range(1, 3));
            ab = ($urandom_range(4) == 0) ? int'($urandom_range(0, W-1)) : W;
            pin_ss(1'b0, 1'b0, 1'b0, '0);
            for (int k = 0; k < nw; k++) begin
                lastw = (k == nw - 1);
                ld_at = ($urandom_range(1) == 1) ? int'($urandom_range(0, W-1)) : -1;
                spi_word(W'($urandom), lastw, ld_at, W'($urandom), lastw ? ab : W, got);
            end
            if (ab == W) finish_xfer();
            else pin_ss(1'b1, $urandom_range(3) == 0, 1'b0, '0);
        end

        repeat (4) tick();
        check_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
